leros_op_issuer: RTL and testbench
==================================

// Module: leros_op_issuer
// PURPOSE
//  Drive end of the accumulator-ALU op interface: accepts 16-bit Leros-style instruction words over valid/ready,
//  buffers them in a small FIFO, decodes op/immediate, and issues them on op/din/ena, one issue per enabled cycle.
//  Sits in front of the accu ALU in the leros test and integration environments and replaces hand-driven stimulus.
// PARAMETERS
//  DW     32  accumulator/din width, >= 8
//  DEPTH  4   instruction FIFO entries, power of two, >= 2
// PORTS
//  clock        in   1      rising-edge clock
//  reset        in   1      synchronous, active-low reset (0 = reset)
//  instr        in   16     instruction word
//  instr_valid  in   1      instr present
//  instr_ready  out  1      FIFO can accept; = reset & !full (combinational)
//  hold         in   1      1 = suppress issue this cycle (downstream stall)
//  op           out  3      leros_op_t to ALU, registered
//  din          out  DW     operand to ALU, registered
//  ena          out  1      ALU enable, registered
//  busy         out  1      FIFO non-empty or issue stage occupied
// BEHAVIOUR
//  - Reset (reset==0 at edge): op=NOP, din=0, ena=0, FIFO empty, issue stage empty, busy=0; instr_ready=0 while reset==0.
//  - Word format: [15:13] op, [12] sext, [11:8] rpt, [7:0] imm8. Unused bits: none.
//  - din = sext ? sign-extend(imm8) to DW : zero-extend(imm8). Computed once when the issue stage loads.
//  - Accept: instr_valid & instr_ready at an edge writes the word to FIFO tail. valid/ready with ready=0 ignored; no drop.
//  - Simultaneous push and pop: allowed at any occupancy; count unchanged. Push while full never happens (ready=0).
//  - Issue FSM: IDLE, ISSUE.
//    IDLE: ena=0. If FIFO non-empty: pop head, load op/din, cnt=rpt -> ISSUE.
//    ISSUE: if hold=1: ena=0, op/din/cnt frozen. Else ena=1 this cycle (op issued, NOP included);
//      if cnt!=0: cnt-- stay; if cnt==0: if FIFO non-empty pop+load next (stay ISSUE) else -> IDLE.
//    ena, op, din are registered outputs of this FSM; each instruction issues exactly rpt+1 enabled cycles.
//  - Latency: word accepted at edge t -> ena=1 during cycle t+2 (hold=0, stage free). Back-to-back words issue
//    with no gap cycles while FIFO stays non-empty.
//  - hold asserted on the final repeat cycle: instruction is not retired; it issues when hold drops.
//  - op/din retain the last issued values in IDLE (ena=0); only ena qualifies them.
//  - busy = (FIFO count != 0) | (state == ISSUE).
//  - Reset mid-operation: pending FIFO contents and repeat count discarded; outputs return to reset values next edge.
// CONFIGURATION
//  LEROS_ISSUE_COUNT_EN defined: extra output port issued_cnt [31:0], reset 0, +1 at every edge where ena=1
//    was asserted, wraps 0xFFFF_FFFF -> 0. Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  - leros_pkg (shared): leros_op_t enum 3 bits {NOP=0,ADD,SUB,AND,OR,XOR,LD,SHR}; field constants
//    OP_MSB/OP_LSB, SEXT_BIT, RPT_MSB/RPT_LSB, IMM_MSB/IMM_LSB; issuer state typedef.
//  - Sub-module leros_sync_fifo (16-bit, DEPTH, push/pop/full/empty, same clock/reset); FSM+decode in top.
// TESTING
//  1. Reset: hold reset=0 3 cycles with instr_valid=1 -> instr_ready=0, ena=0, op=NOP, din=0, busy=0; nothing queued.
//  2. Single LD: push 0xC05A (LD, zext, rpt 0, imm 0x5A) at edge t -> cycle t+2: ena=1, op=LD, din=0x0000005A;
//     t+3: ena=0; accu==0x5A.
//  3. Sign-extend + repeat: push 0x33FF (ADD, sext, rpt 3, imm 0xFF) after LD 0x10 -> 4 consecutive ena cycles,
//     din=0xFFFFFFFF; final accu==0x0C.
//  4. Backpressure/full: DEPTH=4, hold=1, push 6 words -> instr_ready=0 after 4 accepted (+1 in issue stage);
//     release hold -> all 5 accepted words issue in order, no gaps, none lost, 6th accepted once space frees.
//  5. hold mid-repeat: SHR rpt 2, hold=1 on 2nd issue cycle for 2 cycles -> exactly 3 ena pulses total, op/din stable.
//  6. Reset mid-repeat with 3 words queued -> next cycle ena=0, busy=0; with LEROS_ISSUE_COUNT_EN, issued_cnt=0.

Source files
------------

// File: rtl/leros_pkg.sv
// Shared Leros definitions: ALU op encoding, instruction word field positions, issuer state encoding.
package leros_pkg;

    typedef enum logic [2:0] {
        NOP = 3'd0,
        ADD = 3'd1,
        SUB = 3'd2,
        AND = 3'd3,
        OR  = 3'd4,
        XOR = 3'd5,
        LD  = 3'd6,
        SHR = 3'd7
    } leros_op_t;

    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 13;
    localparam int SEXT_BIT = 12;
    localparam int RPT_MSB  = 11;
    localparam int RPT_LSB  = 8;
    localparam int IMM_MSB  = 7;
    localparam int IMM_LSB  = 0;

    typedef logic issue_state_t;
    localparam issue_state_t ST_IDLE  = 1'b0;
    localparam issue_state_t ST_ISSUE = 1'b1;

endpackage

// File: rtl/leros_sync_fifo.sv
// Single-clock FIFO with synchronous active-low reset; simultaneous push/pop allowed at any occupancy.
module leros_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    // Storage needs no reset; pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/leros_op_issuer.sv
// Queues Leros instruction words and issues each one rpt+1 times on op/din/ena to the accumulator ALU.
// Optional LEROS_ISSUE_COUNT_EN adds the issued_cnt output counting enabled issue cycles.
//
//  state    | meaning
//  ST_IDLE  | issue stage empty, ena low; loads the FIFO head when one is present
//  ST_ISSUE | issue stage holds an instruction; issues one repeat per cycle unless hold
module leros_op_issuer
    import leros_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [15:0]   instr,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic          hold,
    output logic [2:0]    op,
    output logic [DW-1:0] din,
    output logic          ena,
    output logic          busy
`ifdef LEROS_ISSUE_COUNT_EN
    ,
    output logic [31:0]   issued_cnt
`endif
);

    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          load;
    logic          issue;
    logic          retire;
    logic [15:0]   head;
    logic [DW-1:0] head_din;

    issue_state_t  state;
    logic [2:0]    stage_op;
    logic [DW-1:0] stage_din;
    logic [3:0]    cnt;

    assign instr_ready = reset & ~fifo_full;
    assign push        = instr_valid & instr_ready;
    assign issue       = (state == ST_ISSUE) & ~hold;
    assign retire      = issue & (cnt == 4'd0);
    assign load        = ~fifo_empty & ((state == ST_IDLE) | retire);
    assign busy        = ~fifo_empty | (state == ST_ISSUE);

    assign head_din = head[SEXT_BIT] ? DW'($signed(head[IMM_MSB:IMM_LSB]))
                                     : DW'(head[IMM_MSB:IMM_LSB]);

    leros_sync_fifo #(
        .WIDTH (16),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (load),
        .wdata (instr),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The issue stage is separate from the output registers so the next word can
    // load on the same edge that the last repeat of the current one is presented.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= ST_IDLE;
            stage_op  <= NOP;
            stage_din <= '0;
            cnt       <= '0;
            op        <= NOP;
            din       <= '0;
            ena       <= 1'b0;
        end else begin
            ena <= issue;
            if (issue) begin
                op  <= stage_op;
                din <= stage_din;
            end
            if (load) begin
                stage_op  <= head[OP_MSB:OP_LSB];
                stage_din <= head_din;
                cnt       <= head[RPT_MSB:RPT_LSB];
                state     <= ST_ISSUE;
            end else if (issue) begin
                if (cnt != 4'd0) cnt <= cnt - 4'd1;
                else             state <= ST_IDLE;
            end
        end
    end

`ifdef LEROS_ISSUE_COUNT_EN
    always_ff @(posedge clock) begin
        if (!reset)   issued_cnt <= '0;
        else if (ena) issued_cnt <= issued_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_leros_op_issuer.sv
// Self-checking bench for leros_op_issuer: directed scenarios plus randomized traffic against an issue-stream model.
module tb_leros_op_issuer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic        hold = 1'b0;
    logic [2:0]  op;
    logic [31:0] din;
    logic        ena;
    logic        busy;
`ifdef LEROS_ISSUE_COUNT_EN
    logic [31:0] issued_cnt;
`endif

    leros_op_issuer #(.DW(32), .DEPTH(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .hold        (hold),
        .op          (op),
        .din         (din),
        .ena         (ena),
        .busy        (busy)
`ifdef LEROS_ISSUE_COUNT_EN
        ,
        .issued_cnt  (issued_cnt)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] din;
    } item_t;

    item_t       exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          ena_seen = 0;
    int          exp_issued = 0;
    int          run_len = 0;
    int          last_run = 0;
    logic [31:0] acc_dut = '0;
    logic [31:0] acc_ref = '0;
    logic        hold_q = 1'b0;
    logic        reset_q = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu(input logic [31:0] a, input logic [2:0] o, input logic [31:0] d);
        case (o)
            3'd1:    return a + d;
            3'd2:    return a - d;
            3'd3:    return a & d;
            3'd4:    return a | d;
            3'd5:    return a ^ d;
            3'd6:    return d;
            3'd7:    return a >> 1;
            default: return a;
        endcase
    endfunction

    // Each accepted word becomes rpt+1 identical issue slots.
    task automatic model_accept(input logic [15:0] w);
        item_t it;
        int    imm;
        imm = int'(w[7:0]);
        it.op  = w[15:13];
        it.din = (w[12] && imm >= 128) ? 32'(imm) + 32'hFFFF_FF00 : 32'(imm);
        for (int r = 0; r <= int'(w[11:8]); r++) exp_q.push_back(it);
    endtask

    always @(posedge clock) begin
        hold_q  <= hold;
        reset_q <= reset;
    end

    always @(negedge clock) begin
        if (!reset_q) begin
            check_val("rst_ena", 64'(ena), 64'd0);
            check_val("rst_op", 64'(op), 64'd0);
            check_val("rst_din", 64'(din), 64'd0);
        end else if (hold_q) begin
            check_val("hold_ena", 64'(ena), 64'd0);
        end
        if (ena) begin
            ena_seen++;
            run_len++;
            acc_dut = alu(acc_dut, op, din);
            if (exp_q.size() == 0) begin
                check_val("spurious_ena", 64'd1, 64'd0);
            end else begin
                item_t it;
                it = exp_q.pop_front();
                exp_issued++;
                acc_ref = alu(acc_ref, it.op, it.din);
                check_val("issue_op", 64'(op), 64'(it.op));
                check_val("issue_din", 64'(din), 64'(it.din));
            end
        end else if (run_len != 0) begin
            last_run = run_len;
            run_len  = 0;
        end
    end

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic push_word(input logic [15:0] w, input bit rnd_hold);
        bit ok;
        ok = 1'b0;
        instr       = w;
        instr_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            logic rdy;
            rdy = instr_ready;
            cycle();
            if (rnd_hold) hold = ($urandom_range(0, 3) == 0);
            if (rdy) begin
                model_accept(w);
                ok = 1'b1;
                break;
            end
        end
        instr_valid = 1'b0;
        if (!ok) check_val("push_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 500; i++) begin
            if (!busy && !ena && exp_q.size() == 0) break;
            cycle();
        end
        cycle();
        check_val("idle_reached", 64'(busy == 1'b0 && exp_q.size() == 0), 64'd1);
    endtask

    initial begin
        int base;

        // 1. reset with valid asserted
        instr       = 16'hC0AA;
        instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_val("t1_ready", 64'(instr_ready), 64'd0);
            check_val("t1_busy", 64'(busy), 64'd0);
        end
        instr_valid = 1'b0;
        reset = 1'b1;
        base = ena_seen;
        for (int i = 0; i < 5; i++) cycle();
        check_val("t1_busy_after", 64'(busy), 64'd0);
        check_val("t1_no_issue", 64'(ena_seen - base), 64'd0);

        // 2. single LD latency
        push_word(16'hC05A, 1'b0);
        check_val("t2_ena_t1", 64'(ena), 64'd0);
        cycle();
        check_val("t2_ena_t1b", 64'(ena), 64'd0);
        cycle();
        check_val("t2_ena_t2", 64'(ena), 64'd1);
        check_val("t2_op", 64'(op), 64'd6);
        check_val("t2_din", 64'(din), 64'h5A);
        cycle();
        check_val("t2_ena_t3", 64'(ena), 64'd0);
        check_val("t2_acc", 64'(acc_dut), 64'h5A);
        check_val("t2_op_retained", 64'(op), 64'd6);

        // 3. sign extension and repeat, back-to-back with the LD
        push_word(16'hC010, 1'b0);
        push_word(16'h33FF, 1'b0);
        wait_idle();
        check_val("t3_run", 64'(last_run), 64'd5);
        check_val("t3_acc", 64'(acc_dut), 64'h0C);
        check_val("t3_din", 64'(din), 64'hFFFF_FFFF);

        // 4. backpressure with hold: 1 in stage + 4 in FIFO
        hold = 1'b1;
        push_word(16'hC001, 1'b0);
        push_word(16'h2002, 1'b0);
        push_word(16'h1083, 1'b0);
        push_word(16'h8004, 1'b0);
        push_word(16'hA005, 1'b0);
        check_val("t4_ready_full", 64'(instr_ready), 64'd0);
        check_val("t4_busy", 64'(busy), 64'd1);
        check_val("t4_no_issue", 64'(ena), 64'd0);
        hold = 1'b0;
        push_word(16'h6006, 1'b0);
        wait_idle();
        check_val("t4_run", 64'(last_run), 64'd6);

        // 5. hold in the middle of a SHR repeat
        push_word(16'hC040, 1'b0);
        wait_idle();
        base = ena_seen;
        push_word(16'hE200, 1'b0);
        cycle();
        cycle();
        check_val("t5_first", 64'(ena), 64'd1);
        hold = 1'b1;
        cycle();
        check_val("t5_hold_op", 64'(op), 64'd7);
        cycle();
        check_val("t5_hold_din", 64'(din), 64'd0);
        hold = 1'b0;
        wait_idle();
        check_val("t5_pulses", 64'(ena_seen - base), 64'd3);
        check_val("t5_acc", 64'(acc_dut), 64'h08);

        // 6. reset mid-repeat with 3 words queued
        hold = 1'b1;
        push_word(16'h1501, 1'b0);
        push_word(16'h1001, 1'b0);
        push_word(16'h1001, 1'b0);
        push_word(16'h1001, 1'b0);
        hold = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
        exp_q.delete();
        exp_issued = 0;
        acc_ref = acc_dut;
        check_val("t6_ena", 64'(ena), 64'd0);
        check_val("t6_busy", 64'(busy), 64'd0);
        check_val("t6_ready", 64'(instr_ready), 64'd0);
`ifdef LEROS_ISSUE_COUNT_EN
        check_val("t6_cnt", 64'(issued_cnt), 64'd0);
`endif
        reset = 1'b1;
        base = ena_seen;
        for (int i = 0; i < 6; i++) cycle();
        check_val("t6_no_issue", 64'(ena_seen - base), 64'd0);
        check_val("t6_busy_after", 64'(busy), 64'd0);

        // 7. randomized traffic with random hold and gaps
        for (int n = 0; n < 40; n++) begin
            logic [15:0] w;
            w = 16'($urandom);
            w[11:8] = 4'($urandom_range(0, 3));
            push_word(w, 1'b1);
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                hold = ($urandom_range(0, 3) == 0);
                cycle();
            end
        end
        hold = 1'b0;
        wait_idle();
        check_val("t7_acc", 64'(acc_dut), 64'(acc_ref));
`ifdef LEROS_ISSUE_COUNT_EN
        check_val("t7_cnt", 64'(issued_cnt), 64'(exp_issued));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
